// File: rtl/k2red_digit_mul_pkg.sv
// Package k2red_pkg: shared constants and types for the K2-RED digit-serial
// multiplier.
//   W_DEFAULT / D_DEFAULT : default operand width and digit width
//   N_DEFAULT             : digits per operand (W/D), i.e. MUL cycles per product
//   CNT_W                 : digit counter width, never below 1
//   state_t               : FSM encoding; 2'd3 is illegal and recovers to IDLE
package k2red_pkg;

  localparam int W_DEFAULT = 64;
  localparam int D_DEFAULT = 16;
  localparam int N_DEFAULT = W_DEFAULT / D_DEFAULT;

  // A one-digit configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(N_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/k2red_digit_mul_if.sv
// Handshake bundle between an operand producer / product consumer (master)
// and the digit-serial multiplier (slave).
//   in_valid  : master -> slave, operand pair valid
//   in_ready  : slave  -> master, multiplier can accept an operand pair
//   a, b      : master -> slave, W-bit unsigned operands
//   out_valid : slave  -> master, P holds a completed product
//   out_ready : master -> slave, consumer accepts P
//   P         : slave  -> master, 2W-bit unsigned product
interface k2red_digit_mul_if
  import k2red_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] P;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, P
  );

endinterface

// File: rtl/k2red_digit_mul_mac.sv
// k2red_digit_mac: combinational partial-product accumulate step.
//   o_sum = i_acc + ((i_x * i_d) << (D * i_k))
// Ports:
//   i_x   : W-bit multiplicand
//   i_d   : D-bit digit of the multiplier
//   i_k   : digit index (shift = D*i_k, always < W)
//   i_acc : 2W-bit running accumulator
//   o_sum : 2W-bit updated accumulator (cannot overflow for a W x W product)
module k2red_digit_mac
  import k2red_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int D     = D_DEFAULT,
  parameter int CNT_W = k2red_pkg::CNT_W
) (
  input  logic [W-1:0]     i_x,
  input  logic [D-1:0]     i_d,
  input  logic [CNT_W-1:0] i_k,
  input  logic [2*W-1:0]   i_acc,
  output logic [2*W-1:0]   o_sum
);

  logic [W+D-1:0] w_prod;
  logic [2*W-1:0] w_prod_ext;
  logic [2*W-1:0] w_term;

  always_comb begin
    // Both factors widened to W+D so the product keeps every bit.
    w_prod     = {{D{1'b0}}, i_x} * {{W{1'b0}}, i_d};
    w_prod_ext = '0;
    w_prod_ext[W+D-1:0] = w_prod;
    w_term     = w_prod_ext << (D * int'(i_k));
  end

  assign o_sum = i_acc + w_term;

endmodule

// File: rtl/k2red_digit_mul.sv
// k2red_digit_mul: iterative digit-serial W x W unsigned multiplier feeding
// the K2-RED reducer. Consumes D bits of b per MUL cycle, N = W/D cycles per
// product, valid/ready handshake on both sides.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset; discards any in-flight product
//   bus : k2red_digit_mul_if slave modport (in_valid/in_ready/a/b,
//         out_valid/out_ready/P)
// Optional build macro K2RED_MUL_OVERLAP_EN: lets a new operand pair be
// accepted on the same edge the finished product is handed off (DONE->MUL),
// giving one product every N+1 cycles instead of N+2.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// MUL   | accumulating one D-bit digit of b per cycle
// DONE  | product valid on P, held until out_ready
module k2red_digit_mul
  import k2red_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int D = D_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  k2red_digit_mul_if.slave bus
);

  localparam int N      = W / D;
  localparam int CNT_WL = cnt_width(N);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_WL-1:0]   r_cnt;
  logic [W-1:0]        r_areg;
  logic [W-1:0]        r_breg;
  logic [2*W-1:0]      r_acc;
  logic [2*W-1:0]      r_p;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_accept;
  logic                w_handoff;
  logic                w_last;
  logic [2*W-1:0]      w_mac_sum;

  // Handshake flags come from the state register; rst only masks in_ready
  // so nothing is accepted while reset is held.
  assign w_out_valid = (r_state == DONE);
`ifdef K2RED_MUL_OVERLAP_EN
  assign w_in_ready  = ~rst & ((r_state == IDLE) |
                               ((r_state == DONE) & bus.out_ready));
`else
  assign w_in_ready  = ~rst & (r_state == IDLE);
`endif

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_handoff = w_out_valid & bus.out_ready;
  assign w_last    = (r_cnt == CNT_WL'(N - 1));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.P         = r_p;

  k2red_digit_mac #(
    .W     (W),
    .D     (D),
    .CNT_W (CNT_WL)
  ) u_mac (
    .i_x   (r_areg),
    .i_d   (r_breg[D-1:0]),
    .i_k   (r_cnt),
    .i_acc (r_acc),
    .o_sum (w_mac_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = MUL;
      end
      MUL: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_handoff) w_state_nxt = w_accept ? MUL : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_areg  <= '0;
      r_breg  <= '0;
      r_acc   <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_areg <= bus.a;
        r_breg <= bus.b;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == MUL) begin
        r_acc  <= w_mac_sum;
        r_breg <= r_breg >> D;
        r_cnt  <= r_cnt + 1'b1;
      end
      // P only changes at the end of MUL, so it survives an overlapped
      // handoff/accept edge untouched.
      if ((r_state == MUL) && w_last) r_p <= w_mac_sum;
    end
  end

endmodule

// File: tb/tb_k2red_digit_mul.sv
module tb_k2red_digit_mul;
  import k2red_pkg::*;

  localparam int W = 64;
  localparam int D = 16;
  localparam int N = W / D;
`ifdef K2RED_MUL_OVERLAP_EN
  localparam int SPACING = N + 1;
`else
  localparam int SPACING = N + 2;
`endif

  logic clk;
  logic rst;

  k2red_digit_mul_if #(.W(W)) bus ();

  k2red_digit_mul #(.W(W), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [127:0] sb[$];
  logic [127:0] mon_exp;
  int n_cmp = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_acc_mon = 0;
  int n_prod = 0;
  int cycle = 0;
  int last_acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (timeout)", name);
  endtask

  // Scoreboard monitor: samples mid-cycle, pops on every out handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) n_acc_mon++;
      if (bus.out_valid && bus.out_ready) begin
        n_prod++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_product got=%h expected=none", bus.P);
        end else begin
          mon_exp = sb.pop_front();
          chk("product", bus.P, mon_exp);
        end
      end
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      if (bus.in_ready) begin
        sb.push_back(exp);
        n_push++;
        last_acc = cycle;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) fail_msg("accept_wait");
  endtask

  task automatic drain();
    bit done = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      if (sb.size() == 0 && !bus.out_valid) done = 1;
      else step();
    end
    if (!done) fail_msg("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int prev;
    logic [63:0] ra, rb;
    int acc0, prod0;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_P", bus.P, 0);
    @(posedge clk);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    step();

    // Full-scale operands, latency check.
    bus.out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      step();
      if (bus.out_valid) lat = k;
    end
    chk("latency", lat, N);
    drain();

    // Identity and zero.
    send(64'h0123_4567_89AB_CDEF, 64'd1, 128'h0000_0000_0000_0000_0123_4567_89AB_CDEF);
    send(64'd0, 64'hDEAD_BEEF, 128'd0);
    drain();

    // Unbounded stall in DONE.
    bus.out_ready = 1'b0;
    send(64'd3, 64'd5, 128'd15);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) step();
    if (!bus.out_valid) fail_msg("stall_out_valid");
    for (int k = 0; k < 6; k++) begin
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_P", bus.P, 128'd15);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);

    // Asynchronous reset while cnt==2.
    send(64'h1234_5678, 64'h9ABC_DEF0, 128'h1234_5678 * 128'h9ABC_DEF0);
    bus.in_valid = 1'b0;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    step();
    step();
    sb.delete();
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", bus.in_ready, 1);
    step();
    for (int k = 0; k < 8; k++) step();
    chk("midrst_no_product", bus.out_valid, 0);
    send(64'd2, 64'd7, 128'd14);
    drain();

    // Back-to-back ops, accept spacing.
    bus.out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      send(ra, rb, 128'(ra) * 128'(rb));
      if (i > 0) chk("b2b_spacing", last_acc - prev, SPACING);
      prev = last_acc;
    end
    drain();

    // Random stalls and in_valid pulses in every state.
    acc0 = n_acc_mon;
    prod0 = n_prod;
    n_push = 0;
    for (int c = 0; c < 300; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid = ($urandom_range(0, 2) == 0);
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      bus.a = ra;
      bus.b = rb;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(128'(ra) * 128'(rb));
        n_push++;
      end
      @(posedge clk);
      #1;
    end
    drain();
    chk("rand_accepts_vs_pushes", n_acc_mon - acc0, n_push);
    chk("rand_accepts_vs_products", n_acc_mon - acc0, n_prod - prod0);
    chk("sb_empty", sb.size(), 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
